// File: rtl/command_encoder_if.sv
// Loader-side bus of the command encoder: session control, field set with
// valid/ready handshake, instruction-memory write port and status.
interface command_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              finish;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        op_code;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        ws;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       address;
  logic              mem_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;
  logic              wrap_err;

  modport master (
    output start, finish, base_addr, in_valid, op_code, rs1, rs2, ws, shamt,
           funct, imm, address, mem_stall,
    input  in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, done, wrap_err
  );

  modport slave (
    input  start, finish, base_addr, in_valid, op_code, rs1, rs2, ws, shamt,
           funct, imm, address, mem_stall,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, done, wrap_err
  );
endinterface

// File: rtl/command_encoder.sv
// Command encoder: packs instruction fields into 32-bit words, queues them in
// a small registered FIFO and writes them to consecutive instruction-memory
// addresses during a start..finish load session.
module command_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  command_encoder_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_q [DEPTH];
  logic [31:0]       fifo_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] pointer_q, pointer_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic              wrap_err_q, wrap_err_d;

  logic        full, empty, push, pop;
  logic [31:0] enc_word;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = bus.mem_we;

  assign bus.in_ready   = (state_q == RUN) && !full;
  assign bus.mem_we     = ((state_q == RUN) || (state_q == DRAIN)) && !empty && !bus.mem_stall;
  assign bus.mem_addr   = pointer_q;
  assign bus.mem_wdata  = fifo_q[rd_ptr_q];
  assign bus.word_count = word_count_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.wrap_err   = wrap_err_q;

  // Format-dependent packing; fields outside the selected format are dropped.
  always_comb begin
    enc_word = '0;
    unique case (bus.op_code)
      6'b000000, 6'b010000: enc_word = {bus.op_code, bus.rs1, bus.rs2, bus.ws, bus.shamt, bus.funct};
      6'b000010, 6'b010011: enc_word = {bus.op_code, bus.address};
      default:              enc_word = {bus.op_code, bus.rs1, bus.rs2, bus.imm};
    endcase
  end

  // Next-state: session FSM, FIFO push/pop, write pointer and status.
  always_comb begin
    state_d      = state_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pointer_d    = pointer_q;
    word_count_d = word_count_q;
    wrap_err_d   = wrap_err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = enc_word;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      pointer_d    = pointer_q + ADDR_W'(4);
      word_count_d = word_count_q + ADDR_W'(1);
      if (pointer_q[ADDR_W-1:2] == '1) wrap_err_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d      = RUN;
        pointer_d    = {bus.base_addr[ADDR_W-1:2], 2'b00};
        word_count_d = '0;
        wrap_err_d   = 1'b0;
      end
      RUN:   if (bus.finish) state_d = DRAIN;
      DRAIN: if (empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any session and discards queued words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pointer_q    <= '0;
      word_count_q <= '0;
      wrap_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pointer_q    <= pointer_d;
      word_count_q <= word_count_d;
      wrap_err_q   <= wrap_err_d;
    end
  end

endmodule
